// File: rtl/ren_tile_dispatch.sv
// rtl/ren_tile_dispatch.sv - pops tile entries, clips them to the screen and walks them as 2x2 quads
module ren_tile_dispatch #(
  parameter int COORD_W  = 11,
  parameter int SIZE_W   = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_empty,
  output logic               o_pop,
  input  logic [COORD_W-1:0] i_tile_x,
  input  logic [COORD_W-1:0] i_tile_y,
  input  logic [SIZE_W-1:0]  i_tile_size,
  input  logic               i_flush,
  output logic               o_quad_valid,
  input  logic               i_quad_ready,
  output logic [COORD_W-1:0] o_quad_x,
  output logic [COORD_W-1:0] o_quad_y,
  output logic [3:0]         o_quad_mask,
  output logic               o_quad_last,
  output logic               o_busy
);

  localparam int CW = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t             state;
  logic [COORD_W-1:0] tile_x, tile_y;
  logic [CW-1:0]      eff_w, eff_h, qx, qy;
  logic [CW-1:0]      in_size, in_x, in_y, room_w, room_h, clip_w, clip_h;
  logic [CW-1:0]      nqx, nqy;
  logic               discard, handshake, row_end, tile_end;

  function automatic logic [3:0] quad_mask(input logic [CW-1:0] ox, oy, w, h);
    logic x0, x1, y0, y1;
    x0 = ox < w;
    x1 = (ox + CW'(1)) < w;
    y0 = oy < h;
    y1 = (oy + CW'(1)) < h;
    return {x1 & y1, x0 & y1, x1 & y0, x0 & y0};
  endfunction

  function automatic logic quad_last(input logic [CW-1:0] ox, oy, w, h);
    return ((ox + CW'(2)) >= w) && ((oy + CW'(2)) >= h);
  endfunction

  // Clip of the entry presented on i_tile_* during LOAD
  always_comb begin
    in_size = CW'(i_tile_size);
    in_x    = {1'b0, i_tile_x};
    in_y    = {1'b0, i_tile_y};
    room_w  = CW'(SCREEN_W) - in_x;
    room_h  = CW'(SCREEN_H) - in_y;
    clip_w  = (in_size < room_w) ? in_size : room_w;
    clip_h  = (in_size < room_h) ? in_size : room_h;
    discard = (in_size == '0) || (in_x >= CW'(SCREEN_W)) || (in_y >= CW'(SCREEN_H));
  end

  always_comb begin
    handshake = (state == EMIT) && o_quad_valid && i_quad_ready;
    row_end   = (qx + CW'(2)) >= eff_w;
    tile_end  = row_end && ((qy + CW'(2)) >= eff_h);
    nqx       = row_end ? '0 : qx + CW'(2);
    nqy       = row_end ? qy + CW'(2) : qy;
  end

  // Pop from IDLE, or together with the final handshake so the next tile follows with only the LOAD gap
  assign o_pop  = rst_n && !i_flush && !i_empty &&
                  ((state == IDLE) || (handshake && tile_end));
  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tile_x       <= '0;
      tile_y       <= '0;
      eff_w        <= '0;
      eff_h        <= '0;
      qx           <= '0;
      qy           <= '0;
      o_quad_valid <= 1'b0;
      o_quad_x     <= '0;
      o_quad_y     <= '0;
      o_quad_mask  <= '0;
      o_quad_last  <= 1'b0;
    end else if (i_flush) begin
      state        <= IDLE;
      o_quad_valid <= 1'b0;
      o_quad_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_pop) state <= LOAD;
        end
        LOAD: begin
          tile_x <= i_tile_x;
          tile_y <= i_tile_y;
          eff_w  <= clip_w;
          eff_h  <= clip_h;
          qx     <= '0;
          qy     <= '0;
          if (discard) begin
            state <= IDLE;
          end else begin
            state        <= EMIT;
            o_quad_valid <= 1'b1;
            o_quad_x     <= i_tile_x;
            o_quad_y     <= i_tile_y;
            o_quad_mask  <= quad_mask('0, '0, clip_w, clip_h);
            o_quad_last  <= quad_last('0, '0, clip_w, clip_h);
          end
        end
        EMIT: begin
          if (handshake) begin
            if (tile_end) begin
              state        <= o_pop ? LOAD : IDLE;
              o_quad_valid <= 1'b0;
              o_quad_last  <= 1'b0;
            end else begin
              qx          <= nqx;
              qy          <= nqy;
              o_quad_x    <= tile_x + nqx[COORD_W-1:0];
              o_quad_y    <= tile_y + nqy[COORD_W-1:0];
              o_quad_mask <= quad_mask(nqx, nqy, eff_w, eff_h);
              o_quad_last <= quad_last(nqx, nqy, eff_w, eff_h);
            end
          end
        end
        default: begin
          state        <= IDLE;
          o_quad_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
